// File: rtl/hc_pkg.sv
// hc_pkg: shared widths, generator state encoding and length legality check.
package hc_pkg;
  localparam int CAND_W = 56;
  localparam int CHAR_W = 8;
  localparam int MAX_LEN = 7;
  typedef enum logic [1:0] {IDLE, RUN, DONE} gen_state_t;
  typedef logic [2:0] len_t;
  function automatic logic lens_ok(len_t lo, len_t hi);
    return lo != '0 && lo <= hi;
  endfunction
endpackage

// File: rtl/candidate_gen_if.sv
// candidate_gen_if: write/full handshake and data word into the candidate FIFO.
interface candidate_gen_if;
  import hc_pkg::*;
  logic write;
  logic full;
  logic [CAND_W-1:0] out_data;
  modport master(output write, out_data, input full);
  modport slave(input write, out_data, output full);
endinterface

// File: rtl/cand_digit.sv
// cand_digit: one odometer position; wraps at CHAR_COUNT-1 and carries left.
module cand_digit #(
  parameter int CHAR_COUNT = 26,
  parameter int DW = $clog2(CHAR_COUNT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  input  logic          active,
  output logic [DW-1:0] index,
  output logic          carry_out
);
  logic wrap;
  always_comb begin
    wrap = index == DW'(CHAR_COUNT - 1);
    carry_out = inc && active && wrap;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) index <= '0;
    else if (clr || carry_out) index <= '0;
    else if (inc && active) index <= index + 1'b1;
endmodule

// File: rtl/candidate_gen.sv
// candidate_gen: enumerates min_len..max_len candidates in odometer order into the FIFO.
module candidate_gen
  import hc_pkg::*;
#(
  parameter logic [7:0] CHAR_FIRST = 8'h61,
  parameter int         CHAR_COUNT = 26
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  len_t                   min_len,
  input  len_t                   max_len,
  candidate_gen_if.master        fifo,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            count
);
  localparam int DW = $clog2(CHAR_COUNT);
  gen_state_t state, state_n;
  len_t cur_len, max_l, nl;
  logic go, legal, adv, clr, carry0, grow, last, err_r;
  logic [CAND_W-1:0] out_n;
  assign go = start && !abort && state != RUN;
  assign legal = lens_ok(min_len, max_len);
  assign adv = fifo.write && !abort;
  assign clr = go || grow;
  assign carry0 = g_dig[0].c_out;
  assign grow = carry0 && cur_len < max_l;
  assign last = carry0 && !grow;
  assign nl = go ? min_len : grow ? cur_len + 1'b1 : cur_len;
  // Each digit is fed by its right neighbour's carry; the rightmost live digit takes the accept.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_dig
    logic c_in, c_out, inc, act;
    logic [DW-1:0] idx, d_n;
    if (i == MAX_LEN - 1) begin : g_tail
      assign c_in = 1'b0;
    end else begin : g_link
      assign c_in = g_dig[i+1].c_out;
    end
    assign act = len_t'(i) < cur_len;
    assign inc = (adv && cur_len == len_t'(i + 1)) || c_in;
    assign d_n = (clr || c_out) ? '0 : idx + DW'(inc && act);
    assign out_n[CAND_W-1-CHAR_W*i -: CHAR_W] = len_t'(i) < nl ? CHAR_FIRST + CHAR_W'(d_n) : '0;
    cand_digit #(.CHAR_COUNT(CHAR_COUNT), .DW(DW)) u_digit (
      .clk,
      .reset,
      .inc,
      .clr,
      .active(act),
      .index(idx),
      .carry_out(c_out)
    );
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (abort) state_n = IDLE;
    else if (go) state_n = legal ? RUN : DONE;
    else if (state == RUN && last) state_n = DONE;
  end
  always_comb begin
    busy = state == RUN;
    done = state == DONE;
    err = done && err_r;
    fifo.write = busy && !fifo.full;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cur_len <= '0;
      max_l <= '0;
      err_r <= 1'b0;
      count <= '0;
      fifo.out_data <= '0;
    end else begin
      if (go) begin
        cur_len <= min_len;
        max_l <= max_len;
        err_r <= !legal;
        count <= '0;
      end else begin
        if (grow) cur_len <= cur_len + 1'b1;
        if (fifo.write && count != '1) count <= count + 1'b1;
      end
      if ((go && legal) || adv) fifo.out_data <= out_n;
    end
endmodule

// File: doc/candidate_gen.md
Name: candidate_gen

Overview:
Upstream producer for the 56-bit candidate FIFO. It enumerates every password candidate of length min_len..max_len over a contiguous character range, in odometer order. It packs each candidate into 56 bits and pushes it into the FIFO through the write/full handshake. It also reports progress (done flag, candidate count) to the host/control logic.

Parameters:
CHAR_FIRST, 8'h61, code of the first charset character ('a').
CHAR_COUNT, 26, number of consecutive charset characters (2..256).
MAX_LEN, 7, maximum candidate length in bytes (fixed by the 56-bit word).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse; begins enumeration when in IDLE or DONE.
abort  input  1  stops enumeration; returns to IDLE.
min_len  input  3  shortest length to generate; sampled on start.
max_len  input  3  longest length to generate; sampled on start.
full  input  1  FIFO full flag.
write  output  1  FIFO write strobe.
out_data  output  56  candidate; byte 0 at [55:48]; unused trailing bytes are 8'h00.
busy  output  1  high in RUN.
done  output  1  high in DONE.
err  output  1  high in DONE when the start parameters were illegal.
count  output  32  candidates accepted since the last start; saturates at 2^32-1.

Behaviour:
- Reset (async): state IDLE; write=0, busy=0, done=0, err=0, count=0, out_data=0, all digit indices 0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start:
  - Legal parameters are 1<=min_len<=max_len<=MAX_LEN.
  - If legal: latch the lengths, set cur_len=min_len, clear all digits to 0, clear count and err, go to RUN.
  - If illegal: go to DONE with err=1 and no writes.
- RUN + start is ignored.
- write = (state==RUN) && !full (combinational, no bubble).
- Acceptance: a candidate is accepted on any cycle with write=1. out_data must be valid and stable whenever state==RUN.
- On acceptance, the odometer advances one step:
  - The last character position (index cur_len-1) increments first.
  - A digit that reaches CHAR_COUNT-1 and then increments wraps to 0 and carries to the position on its left.
  - Carry out of position 0: if cur_len<max_len, cur_len increments and all digits clear to 0. Otherwise this is the final candidate: go to DONE.
- out_data byte i = CHAR_FIRST + digit[i] for i<cur_len; 8'h00 otherwise. It is registered and updated in the same cycle the digits update.
- Full: while full=1 the state, digits, out_data and count hold; no candidate is skipped or duplicated.
- Count: +1 per acceptance.
- Abort:
  - Takes effect at the next edge: goes to IDLE. count and out_data hold their values.
  - A write asserted in the abort cycle still counts.
  - Abort has priority over the final-candidate transition to DONE.
- DONE holds done=1 (and err) until the next start.
- Total candidates = sum over L=min_len..max_len of CHAR_COUNT^L.

Decomposition:
- Shared package hc_pkg:
  - CAND_W=56, CHAR_W=8, MAX_LEN=7.
  - Digit index width: $clog2(CHAR_COUNT), computed locally.
  - gen_state_t enum {IDLE,RUN,DONE}.
- One sub-module, cand_digit:
  - Holds one index register.
  - Inputs: inc, clr, active. Outputs: index, carry_out.
  - Instantiated MAX_LEN times in a ripple chain.

Test Plan:
1. CHAR_COUNT=3, min_len=1, max_len=2, full=0 -> exactly 12 writes in 12 consecutive cycles: a,b,c,aa,ab,...,cc. "ab" appears as 56'h6162_0000_0000_00. done=1 and count=12 afterwards.
2. Same setup, full toggled by a random 50% pattern -> the identical 12-entry sequence with no gaps or duplicates; write never high while full=1.
3. min_len=3, max_len=2 (and separately min_len=0) -> DONE with err=1 one cycle after start; zero writes; count=0.
4. Abort after 5 accepted candidates, then start with min_len=1, max_len=1 -> IDLE after 5 (count=5); the new run emits a,b,c, count=3, done=1.
5. Reset asserted mid-RUN, asynchronously between clock edges -> all outputs drop to reset values immediately; no write on the following edges until a new start.
6. Default parameters, min_len=max_len=1 -> 26 writes 'a'..'z' (8'h61..8'h7A in byte 0, remaining bytes zero); a start pulse during RUN does not disturb the sequence.
